imem_loader: RTL

- Boot-time writer for the instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Drives the instruction memory write port at sequential word-aligned byte addresses.
- Holds the CPU in reset/stall via cpu_hold until the load completes. Sits between the host/serial front-end and the instruction memory.

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_word_packer.sv | 40 ++++
 rtl/imem_loader.sv | 134 +++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_pkg;

  localparam int IMEM_WORD_W         = 32;
  localparam int IMEM_BYTES_PER_WORD = 4;
  localparam int LEN_W               = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } imem_state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles big-endian 32-bit words from a byte stream; word_vld pulses one
// cycle after the 4th byte of each word is accepted.
module imem_word_packer
  import imem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   byte_vld,
  input  logic [7:0]             byte_dat,
  output logic [1:0]             byte_idx,
  output logic                   word_vld,
  output logic [IMEM_WORD_W-1:0] word_dat
);

  logic [IMEM_WORD_W-9:0] shreg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg    <= '0;
      byte_idx <= '0;
      word_vld <= 1'b0;
      word_dat <= '0;
    end else begin
      word_vld <= 1'b0;
      if (clear) begin
        shreg    <= '0;
        byte_idx <= '0;
      end else if (byte_vld) begin
        shreg    <= {shreg[IMEM_WORD_W-17:0], byte_dat};
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'(IMEM_BYTES_PER_WORD - 1)) begin
          word_vld <= 1'b1;
          word_dat <= {shreg, byte_dat};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> sequential instruction memory writes,
// holding the CPU until a complete load. IMEM_LOADER_CHECKSUM_EN adds a trailing XOR byte.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH  = 30,
  parameter int ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [IMEM_WORD_W-1:0] wr_data,
  output logic                   cpu_hold,
  output logic                   done,
  output logic                   error
);

  imem_state_e      state, state_nxt;
  logic             xfer;
  logic [7:0]       len_hi;
  logic [LEN_W-1:0] len_val, n_words, word_idx;
  logic             len_bad, last_byte;
  logic [1:0]       byte_idx;
  logic             pk_vld, pk_clear;

  assign xfer      = in_valid & in_ready;
  assign len_val   = {len_hi, in_data};
  assign len_bad   = (len_val == '0) || (len_val > LEN_W'(DEPTH));
  assign last_byte = (byte_idx == 2'(IMEM_BYTES_PER_WORD - 1)) && (word_idx == n_words - 1'b1);
  assign pk_vld    = xfer && (state == S_DATA);
  assign pk_clear  = xfer && (state == S_LEN_LO);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR over header and payload; the trailing byte must equal it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum <= '0;
    end else if (start && (state == S_IDLE || state == S_DONE || state == S_ERR)) begin
      csum <= '0;
    end else if (xfer && state != S_CSUM) begin
      csum <= csum ^ in_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_hold  = 1'b1;
    case (state)
      S_IDLE: if (start) state_nxt = S_LEN_HI;
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_nxt = S_LEN_HI;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        if (xfer) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        if (xfer) state_nxt = len_bad ? S_ERR : S_DATA;
      end
      S_DATA: begin
        in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (xfer && last_byte) state_nxt = S_CSUM;
`else
        if (xfer && last_byte) state_nxt = S_DONE;
`endif
      end
      S_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        in_ready = 1'b1;
        if (xfer) state_nxt = (in_data == csum) ? S_DONE : S_ERR;
`else
        state_nxt = S_ERR;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address is registered alongside the packer's word strobe so both land together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_hi   <= '0;
      n_words  <= '0;
      word_idx <= '0;
      wr_addr  <= '0;
    end else begin
      if (xfer && state == S_LEN_HI) len_hi <= in_data;
      if (pk_clear) begin
        n_words  <= len_val;
        word_idx <= '0;
      end
      if (pk_vld && byte_idx == 2'(IMEM_BYTES_PER_WORD - 1)) begin
        wr_addr  <= ADDR_W'({word_idx, 2'b00});
        word_idx <= word_idx + 1'b1;
      end
    end
  end

  imem_word_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (pk_clear),
    .byte_vld (pk_vld),
    .byte_dat (in_data),
    .byte_idx (byte_idx),
    .word_vld (wr_en),
    .word_dat (wr_data)
  );

endmodule
